video_timing_gen: RTL

- Generates the raster timing for the DVI output path: counters, hsync, vsync, data-enable and pixel coordinates.
- Runs in the pixel clock domain, directly upstream of the DVI_test TMDS encoder/serialiser stage.
- Default timing is 640x480@60 Hz for a 25 MHz pixel clock.
- Optionally produces an 8-bar colour test pattern aligned to data-enable.

---
 rtl/video_timing_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing generator for the DVI output path. It produces horizontal and
//   vertical counters and, from them, registered hsync / vsync / data-enable,
//   active-area pixel coordinates and line/frame start strobes. It runs in the
//   pixel clock domain and feeds the TMDS encoder / serialiser stage.
//   Default timing is 640x480@60 Hz at a 25 MHz pixel clock.
//
//   Optional build macro: COLORBAR_EN
//     Defined   -> adds the rgb output carrying an 8-bar colour test pattern
//                  registered alongside de.
//     Undefined -> rgb port and its logic are absent.
//
//   H_TOTAL and V_TOTAL must each be <= 2047 to fit the 11-bit counters.
//
// Ports
//   pixclk      in   pixel clock (single domain)
//   resetn      in   asynchronous active-low reset
//   en          in   run enable; low holds the generator at the frame origin
//   hsync       out  horizontal sync, at HS_POL while asserted
//   vsync       out  vertical sync, at VS_POL while asserted
//   de          out  data enable, high in the active area
//   x, y        out  pixel column / row in the active area, 0 in blanking
//   line_start  out  one-cycle pulse for hc == 0
//   frame_start out  one-cycle pulse for hc == 0, vc == 0
//   rgb         out  {R,G,B} colour bars (COLORBAR_EN only)
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixclk,
  input  logic        resetn,
  input  logic        en,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start
`ifdef COLORBAR_EN
  ,
  output logic [23:0] rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized copies of the timing points so every compare is 11 bits wide.
  localparam logic [10:0] H_ACT_W  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_W  = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hc, vc;

  // ---------------------------------------------------------------------------
  // Raster counters. en low parks them at the origin, so the next enabled edge
  // behaves exactly like the first edge after reset release.
  // ---------------------------------------------------------------------------
  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? 11'd0 : vc + 11'd1;
    end else begin
      hc <= hc + 11'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the current counter position; registered below, which gives the
  // one-cycle output latency. vsync only depends on vc, and vc only moves on
  // the hc wrap, so it naturally toggles with the hc == 0 output cycle.
  // ---------------------------------------------------------------------------
  logic de_d, hs_act_d, vs_act_d, ls_d, fs_d;

  always_comb begin
    de_d     = (hc < H_ACT_W) && (vc < V_ACT_W);
    hs_act_d = (hc >= HS_START) && (hc < HS_END);
    vs_act_d = (vc >= VS_START) && (vc < VS_END);
    ls_d     = (hc == 11'd0);
    fs_d     = (hc == 11'd0) && (vc == 11'd0);
  end

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (!en) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_act_d ? HS_POL : ~HS_POL;
      vsync       <= vs_act_d ? VS_POL : ~VS_POL;
      de          <= de_d;
      x           <= de_d ? hc : 11'd0;
      y           <= de_d ? vc : 11'd0;
      line_start  <= ls_d;
      frame_start <= fs_d;
    end
  end

`ifdef COLORBAR_EN
  // ---------------------------------------------------------------------------
  // Colour bars: eight equal-width bars across the active width. The index is
  // only meaningful while de_d is high; outside that rgb is forced to black.
  // ---------------------------------------------------------------------------
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [2:0] bar_idx;
  logic [23:0] bar_rgb;

  always_comb begin
    bar_idx = 3'(hc / BAR_W);
    case (bar_idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  always_ff @(posedge pixclk or negedge resetn) begin
    if (!resetn)      rgb <= '0;
    else if (!en)     rgb <= '0;
    else if (de_d)    rgb <= bar_rgb;
    else              rgb <= '0;
  end
`endif

endmodule
